// File: rtl/riscv_core_mem_port_arbiter.sv
// riscv_core_mem_port_arbiter
// Shares the single AXI memory port between I-cache refill, D-cache refill and
// the D-cache write-through FIFO drain. Only one transaction is in flight at a time.
// A D-cache refill is held off until the store FIFO is empty, so a refill never
// returns data older than a pending store. I-refills may bypass a non-empty FIFO
// at most STARVE_LIMIT times in a row before a drain is forced.
// Optional feature: define MEM_ARB_PERF_EN to add 32-bit completed-transaction
// counters (o_perf_ic_cnt, o_perf_dc_cnt, o_perf_wr_cnt).
module riscv_core_mem_port_arbiter #(
   parameter int ADDR_WIDTH       = 64,
   parameter int CORE_DATA_WIDTH  = 64,
   parameter int FIFO_ENTRY_WIDTH = 128,
   parameter int STARVE_LIMIT     = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_ic_req,
   input  logic [ADDR_WIDTH-1:0]       i_ic_addr,
   output logic                        o_ic_done,
   input  logic                        i_dc_req,
   input  logic [ADDR_WIDTH-1:0]       i_dc_addr,
   output logic                        o_dc_done,
   input  logic                        i_fifo_empty,
   input  logic [FIFO_ENTRY_WIDTH-1:0] i_fifo_entry,
   output logic                        o_fifo_pop,
   output logic                        o_axi_rd_req,
   output logic [ADDR_WIDTH-1:0]       o_axi_rd_addr,
   input  logic                        i_axi_rd_done,
   output logic                        o_axi_wr_req,
   output logic [ADDR_WIDTH-1:0]       o_axi_wr_addr,
   output logic [CORE_DATA_WIDTH-1:0]  o_axi_wr_data,
   input  logic                        i_axi_wr_done,
   output logic                        o_busy
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]                 o_perf_ic_cnt,
   output logic [31:0]                 o_perf_dc_cnt,
   output logic [31:0]                 o_perf_wr_cnt
`endif
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_IC    = 2'd1,
      ST_RD_DC    = 2'd2,
      ST_WR_DRAIN = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     state_nxt_s;
   logic                       grant_ic_s;
   logic                       grant_dc_s;
   logic                       grant_wr_s;
   logic                       starved_s;
   logic [CNT_W-1:0]           starve_cnt_r;
   logic [ADDR_WIDTH-1:0]      rd_addr_r;
   logic [ADDR_WIDTH-1:0]      wr_addr_r;
   logic [CORE_DATA_WIDTH-1:0] wr_data_r;

   logic                       rd_req_s;
   logic                       wr_req_s;
   logic                       ic_done_s;
   logic                       dc_done_s;
   logic                       fifo_pop_s;
   logic                       busy_s;

   assign starved_s = (starve_cnt_r == STARVE_MAX);

   // State register: synchronous reset abandons any transaction in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and grant decode; arbitration happens only in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      grant_ic_s  = 1'b0;
      grant_dc_s  = 1'b0;
      grant_wr_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!i_fifo_empty && (starved_s || !i_ic_req)) begin
               grant_wr_s  = 1'b1;
               state_nxt_s = ST_WR_DRAIN;
            end else if (i_ic_req) begin
               grant_ic_s  = 1'b1;
               state_nxt_s = ST_RD_IC;
            end else if (i_dc_req && i_fifo_empty) begin
               grant_dc_s  = 1'b1;
               state_nxt_s = ST_RD_DC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD_IC, ST_RD_DC: begin
            if (i_axi_rd_done) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_WR_DRAIN: begin
            if (i_axi_wr_done) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WR_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Capture address/data at grant so the AXI side sees stable values until done.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_addr_r <= {ADDR_WIDTH{1'b0}};
         wr_addr_r <= {ADDR_WIDTH{1'b0}};
         wr_data_r <= {CORE_DATA_WIDTH{1'b0}};
      end else begin
         if (grant_ic_s) begin
            rd_addr_r <= i_ic_addr;
         end else if (grant_dc_s) begin
            rd_addr_r <= i_dc_addr;
         end else begin
            rd_addr_r <= rd_addr_r;
         end
         if (grant_wr_s) begin
            wr_addr_r <= i_fifo_entry[CORE_DATA_WIDTH +: ADDR_WIDTH];
            wr_data_r <= i_fifo_entry[CORE_DATA_WIDTH-1:0];
         end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
         end
      end
   end

   // Starvation counter: I-refill grants that bypassed a non-empty FIFO.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_IDLE) begin
         if (grant_wr_s || i_fifo_empty) begin
            starve_cnt_r <= {CNT_W{1'b0}};
         end else if (grant_ic_s && !starved_s) begin
            starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Output decode; done/pop pulses are suppressed while reset is asserted.
   always_comb begin
      rd_req_s   = 1'b0;
      wr_req_s   = 1'b0;
      ic_done_s  = 1'b0;
      dc_done_s  = 1'b0;
      fifo_pop_s = 1'b0;
      busy_s     = (state_r != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            rd_req_s = 1'b0;
            wr_req_s = 1'b0;
         end
         ST_RD_IC: begin
            rd_req_s  = !i_axi_rd_done;
            ic_done_s = i_axi_rd_done && !i_rst;
         end
         ST_RD_DC: begin
            rd_req_s  = !i_axi_rd_done;
            dc_done_s = i_axi_rd_done && !i_rst;
         end
         ST_WR_DRAIN: begin
            wr_req_s   = 1'b1;
            fifo_pop_s = i_axi_wr_done && !i_rst;
         end
         default: begin
            rd_req_s = 1'b0;
            wr_req_s = 1'b0;
         end
      endcase
   end

   assign o_axi_rd_req  = rd_req_s;
   assign o_axi_wr_req  = wr_req_s;
   assign o_ic_done     = ic_done_s;
   assign o_dc_done     = dc_done_s;
   assign o_fifo_pop    = fifo_pop_s;
   assign o_busy        = busy_s;
   assign o_axi_rd_addr = rd_addr_r;
   assign o_axi_wr_addr = wr_addr_r;
   assign o_axi_wr_data = wr_data_r;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_ic_r;
   logic [31:0] perf_dc_r;
   logic [31:0] perf_wr_r;

   // Completed-transaction counters, free-running with natural 32-bit wrap.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         perf_ic_r <= 32'd0;
         perf_dc_r <= 32'd0;
         perf_wr_r <= 32'd0;
      end else begin
         perf_ic_r <= ic_done_s  ? perf_ic_r + 32'd1 : perf_ic_r;
         perf_dc_r <= dc_done_s  ? perf_dc_r + 32'd1 : perf_dc_r;
         perf_wr_r <= fifo_pop_s ? perf_wr_r + 32'd1 : perf_wr_r;
      end
   end

   assign o_perf_ic_cnt = perf_ic_r;
   assign o_perf_dc_cnt = perf_dc_r;
   assign o_perf_wr_cnt = perf_wr_r;
`endif

endmodule
